alu4_wb_stage: RTL and testbench

- Registered write-back/result stage directly downstream of the 4-bit ALU.
- Captures each ALU result, its zero/overflow/carry flags and its 3-bit op code into a small FIFO, and presents them to the consumer over a valid/ready handshake.
- Maintains an architectural flag register and a sticky signed-overflow bit.
- Decouples the combinational ALU from a consumer that may stall (register file write port, display/debug logic).

---
 rtl/alu4_pkg.sv | 25 ++
 rtl/alu4_wb_fifo.sv | 56 +++++
 rtl/alu4_wb_stage.sv | 132 +++++++++++++
 tb/tb_alu4_wb_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU and its write-back stage.
package alu4_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned ENTRY_W = DATA_W + 6;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    // Only add, sub and signed less-than produce a meaningful signed overflow.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu4_wb_fifo.sv
// Generic DEPTH x WIDTH FIFO with wrapping pointers and a separate occupancy count.
module alu4_wb_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/alu4_wb_stage.sv
// Write-back stage behind the 4-bit ALU: result FIFO, flag register, sticky overflow.
// Optional statistics counters are built when ALU4_WB_STAT_EN is defined.
module alu4_wb_stage
    import alu4_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_result,
    input  logic         in_zero,
    input  logic         in_overflow,
    input  logic         in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   out_op,
    output logic [W-1:0] out_result,
    output logic         out_zero,
    output logic         out_overflow,
    output logic         out_carry,
    output logic [2:0]   flags,
    output logic         ovf_sticky,
    input  logic         clr_sticky,
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_stall
);

    localparam int unsigned EW = W + 6;

    logic          push, pop, full, empty;
    logic [EW-1:0] wdata, rdata;
    logic [2:0]    flags_q, flags_d;
    logic          sticky_q, sticky_d;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wdata = {in_op, in_result, in_zero, in_overflow, in_carry};

    alu4_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_op       = rdata[EW-1 -: 3];
    assign out_result   = rdata[W+2:3];
    assign out_zero     = rdata[FLAG_Z];
    assign out_overflow = rdata[FLAG_V];
    assign out_carry    = rdata[FLAG_C];

    // Sticky set has priority over a same-cycle clear.
    always_comb begin
        flags_d  = flags_q;
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (push) begin
            flags_d = {in_zero, in_overflow, in_carry};
            if (in_overflow && is_signed_op(in_op)) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
        end
    end

    assign flags      = flags_q;
    assign ovf_sticky = sticky_q;

`ifdef ALU4_WB_STAT_EN
    logic [15:0] ops_q, ops_d;
    logic [15:0] stall_q, stall_d;

    // Saturating counters; clear beats a same-cycle increment.
    always_comb begin
        ops_d   = ops_q;
        stall_d = stall_q;
        if (clr_sticky) begin
            ops_d   = '0;
            stall_d = '0;
        end else begin
            if (push && ops_q != 16'hFFFF) begin
                ops_d = ops_q + 16'd1;
            end
            if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            ops_q   <= ops_d;
            stall_q <= stall_d;
        end
    end

    assign stat_ops   = ops_q;
    assign stat_stall = stall_q;
`else
    assign stat_ops   = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_alu4_wb_stage.sv
// Directed self-checking bench for alu4_wb_stage.
module tb_alu4_wb_stage;

    localparam int unsigned W = 4;
`ifdef ALU4_WB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_result;
    logic         in_zero, in_overflow, in_carry;
    logic         out_valid, out_ready;
    logic [2:0]   out_op;
    logic [W-1:0] out_result;
    logic         out_zero, out_overflow, out_carry;
    logic [2:0]   flags;
    logic         ovf_sticky, clr_sticky;
    logic [15:0]  stat_ops, stat_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu4_wb_stage #(.W(W), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_carry     (in_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_carry    (out_carry),
        .flags        (flags),
        .ovf_sticky   (ovf_sticky),
        .clr_sticky   (clr_sticky),
        .stat_ops     (stat_ops),
        .stat_stall   (stat_stall)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] res,
                         input logic z, input logic v, input logic c);
        in_valid    = 1'b1;
        in_op       = op;
        in_result   = res;
        in_zero     = z;
        in_overflow = v;
        in_carry    = c;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_result = '0;
        in_zero = 1'b0; in_overflow = 1'b0; in_carry = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        #12;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_flags", 16'(flags), 16'd0);
        chk("rst_sticky", 16'(ovf_sticky), 16'd0);
        chk("rst_result", 16'(out_result), 16'd0);
        chk("rst_stat_ops", stat_ops, 16'd0);
        chk("rst_stat_stall", stat_stall, 16'd0);
        rst_n = 1'b1;
        step();

        // Single add with overflow
        drive(3'b000, 4'h9, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        chk("no_bypass", 16'(out_valid), 16'd0);
        step();
        in_valid = 1'b0;
        chk("single_valid", 16'(out_valid), 16'd1);
        chk("single_result", 16'(out_result), 16'h9);
        chk("single_op", 16'(out_op), 16'd0);
        chk("single_ovf", 16'(out_overflow), 16'd1);
        chk("single_flags", 16'(flags), 16'b010);
        chk("single_sticky", 16'(ovf_sticky), 16'd1);
        step();
        chk("single_drained", 16'(out_valid), 16'd0);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("sticky_cleared", 16'(ovf_sticky), 16'd0);
        chk("clr_stat_ops", stat_ops, 16'd0);

        // Backpressure: fill, stall, then drain in order
        out_ready = 1'b0;
        drive(3'b011, 4'h1, 1'b0, 1'b0, 1'b1);
        step();
        chk("bp1_flags", 16'(flags), 16'b001);
        chk("bp1_head", 16'(out_result), 16'h1);
        drive(3'b100, 4'h2, 1'b0, 1'b1, 1'b0);
        step();
        chk("bp2_sticky_filtered", 16'(ovf_sticky), 16'd0);
        chk("bp2_flags", 16'(flags), 16'b010);
        drive(3'b101, 4'h3, 1'b1, 1'b0, 1'b0);
        chk("full_in_ready", 16'(in_ready), 16'd0);
        step();
        step();
        chk("full_hold_ready", 16'(in_ready), 16'd0);
        chk("full_hold_head", 16'(out_result), 16'h1);
        out_ready = 1'b1;
        step();
        chk("pop_full_ready", 16'(in_ready), 16'd1);
        chk("pop_full_valid", 16'(out_valid), 16'd1);
        chk("pop_full_head2", 16'(out_result), 16'h2);
        chk("pop_full_no_push_flags", 16'(flags), 16'b010);
        step();
        in_valid = 1'b0;
        chk("bp3_head", 16'(out_result), 16'h3);
        chk("bp3_op", 16'(out_op), 16'd5);
        chk("bp3_zero", 16'(out_zero), 16'd1);
        chk("bp3_flags", 16'(flags), 16'b100);
        step();
        chk("bp_drained", 16'(out_valid), 16'd0);

        // Streaming push with simultaneous pop
        drive(3'b000, 4'h7, 1'b0, 1'b0, 1'b0);
        step();
        chk("stream7", 16'(out_result), 16'h7);
        drive(3'b001, 4'h8, 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("stream8", 16'(out_result), 16'h8);
        chk("stream_occ1_ready", 16'(in_ready), 16'd1);
        chk("stream_carry", 16'(out_carry), 16'd1);
        step();
        chk("stream_drained", 16'(out_valid), 16'd0);
        chk("stat_ops5", stat_ops, STAT ? 16'd5 : 16'd0);
        chk("stat_stall3", stat_stall, STAT ? 16'd3 : 16'd0);

        // Signed less-than overflow with same-cycle clear: set wins
        drive(3'b110, 4'h1, 1'b0, 1'b1, 1'b0);
        clr_sticky = 1'b1;
        step();
        in_valid = 1'b0;
        clr_sticky = 1'b0;
        chk("slt_sticky_set_wins", 16'(ovf_sticky), 16'd1);
        chk("slt_flags", 16'(flags), 16'b010);
        chk("clr_wins_ops", stat_ops, 16'd0);
        chk("clr_wins_stall", stat_stall, 16'd0);
        step();

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(3'b010, 4'hA, 1'b0, 1'b0, 1'b1);
        step();
        drive(3'b111, 4'hB, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 16'(out_valid), 16'd1);
        chk("pre_rst_full", 16'(in_ready), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_ready", 16'(in_ready), 16'd1);
        chk("mid_rst_flags", 16'(flags), 16'd0);
        chk("mid_rst_sticky", 16'(ovf_sticky), 16'd0);
        chk("mid_rst_result", 16'(out_result), 16'd0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("post_rst_empty", 16'(out_valid), 16'd0);
        chk("post_rst_ready", 16'(in_ready), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
